// File: rtl/pixel_axi4_burst_tx.sv
// Packs grayscale pixels into DATA_W beats and writes them as AXI4 INCR bursts.
// Optional BRESP error counter: define PIXEL_AXI4_BRESP_ERR_CNT_EN.
module pixel_axi4_burst_tx #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 32,
    parameter int MST_ID_W     = 5,
    parameter int TRANS_RESP_W = 2,
    parameter int PXL_W        = 8,
    parameter int BURST_LEN    = 16,
    parameter int FRAME_PXL    = 76800,
    parameter int MST_ID       = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [PXL_W-1:0]        pxl_i,
    input  logic                    pxl_vld_i,
    input  logic                    pxl_sof_i,
    output logic                    pxl_rdy_o,
    input  logic [ADDR_W-1:0]       dcr_pxl_addr_i,
    output logic [MST_ID_W-1:0]     s_awid_o,
    output logic [ADDR_W-1:0]       s_awaddr_o,
    output logic [7:0]              s_awlen_o,
    output logic [2:0]              s_awsize_o,
    output logic [1:0]              s_awburst_o,
    output logic                    s_awvalid_o,
    input  logic                    s_awready_i,
    output logic [DATA_W-1:0]       s_wdata_o,
    output logic [DATA_W/8-1:0]     s_wstrb_o,
    output logic                    s_wlast_o,
    output logic                    s_wvalid_o,
    input  logic                    s_wready_i,
    input  logic [MST_ID_W-1:0]     s_bid_i,
    input  logic [TRANS_RESP_W-1:0] s_bresp_i,
    input  logic                    s_bvalid_i,
    output logic                    s_bready_o,
    output logic                    frame_done_o,
    output logic                    busy_o
`ifdef PIXEL_AXI4_BRESP_ERR_CNT_EN
    ,
    output logic [15:0]             err_cnt_o
`endif
);

    localparam int PPB   = DATA_W / PXL_W;
    localparam int BYTES = DATA_W / 8;
    localparam int PCW   = (PPB > 1) ? $clog2(PPB) : 1;
    localparam int BIW   = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int FCW   = $clog2(FRAME_PXL + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_AW,
        S_W,
        S_B
    } state_e;

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   buf_q [BURST_LEN];
    logic [DATA_W-1:0]   buf_d [BURST_LEN];
    logic [PCW-1:0]      pix_q, pix_d;
    logic [8:0]          beat_q, beat_d;
    logic [FCW-1:0]      frm_q, frm_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [7:0]          len_q, len_d;
    logic [7:0]          wbeat_q, wbeat_d;
    logic                last_q, last_d;

    logic                pxl_acc, sof_acc, b_acc;
    logic [PCW-1:0]      eff_pix;
    logic [8:0]          eff_beat;
    logic [FCW-1:0]      eff_frm;
    logic [BIW-1:0]      idx;
    logic                b_unused;

    assign pxl_acc  = pxl_vld_i && (state_q == S_IDLE || state_q == S_FILL);
    assign sof_acc  = pxl_acc && pxl_sof_i;
    assign b_acc    = (state_q == S_B) && s_bvalid_i;
    assign b_unused = ^{s_bid_i, s_bresp_i};

    // An accepted SOF packs as pixel 0 of a fresh frame.
    assign eff_pix  = sof_acc ? '0 : pix_q;
    assign eff_beat = sof_acc ? '0 : beat_q;
    assign eff_frm  = sof_acc ? '0 : frm_q;
    assign idx      = eff_beat[BIW-1:0];

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        pix_d   = pix_q;
        beat_d  = beat_q;
        frm_d   = frm_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wbeat_d = wbeat_q;
        last_d  = last_q;
        unique case (state_q)
            S_IDLE, S_FILL: begin
                if (sof_acc || (pxl_acc && state_q == S_FILL)) begin
                    if (sof_acc)
                        addr_d = dcr_pxl_addr_i;
                    if (eff_pix == '0)
                        buf_d[idx] = DATA_W'(pxl_i);
                    else
                        buf_d[idx][eff_pix*PXL_W +: PXL_W] = pxl_i;
                    if (eff_pix == PCW'(PPB - 1)) begin
                        pix_d  = '0;
                        beat_d = eff_beat + 9'd1;
                    end else begin
                        pix_d  = eff_pix + 1'b1;
                        beat_d = eff_beat;
                    end
                    frm_d   = eff_frm + 1'b1;
                    state_d = S_FILL;
                    if (frm_d == FCW'(FRAME_PXL) || beat_d == 9'(BURST_LEN)) begin
                        state_d = S_AW;
                        len_d   = eff_beat[7:0];
                        last_d  = (frm_d == FCW'(FRAME_PXL));
                        wbeat_d = '0;
                    end
                end
            end
            S_AW: begin
                if (s_awready_i)
                    state_d = S_W;
            end
            S_W: begin
                if (s_wready_i) begin
                    if (wbeat_q == len_q)
                        state_d = S_B;
                    else
                        wbeat_d = wbeat_q + 8'd1;
                end
            end
            S_B: begin
                if (s_bvalid_i) begin
                    addr_d = addr_q + ADDR_W'(({1'b0, len_q} + 9'd1) * BYTES);
                    pix_d  = '0;
                    beat_d = '0;
                    state_d = last_q ? S_IDLE : S_FILL;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            for (int i = 0; i < BURST_LEN; i++)
                buf_q[i] <= '0;
            pix_q   <= '0;
            beat_q  <= '0;
            frm_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            wbeat_q <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            pix_q   <= pix_d;
            beat_q  <= beat_d;
            frm_q   <= frm_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wbeat_q <= wbeat_d;
            last_q  <= last_d;
        end
    end

    // Ready is gated by reset so every output idles low while rst_n is low.
    assign pxl_rdy_o    = rst_n && (state_q == S_IDLE || state_q == S_FILL);
    assign s_awid_o     = MST_ID_W'(MST_ID);
    assign s_awaddr_o   = addr_q;
    assign s_awlen_o    = len_q;
    assign s_awsize_o   = 3'($clog2(BYTES));
    assign s_awburst_o  = 2'b01;
    assign s_awvalid_o  = (state_q == S_AW);
    assign s_wvalid_o   = (state_q == S_W);
    assign s_wdata_o    = s_wvalid_o ? buf_q[wbeat_q[BIW-1:0]] : '0;
    assign s_wstrb_o    = '1;
    assign s_wlast_o    = s_wvalid_o && (wbeat_q == len_q);
    assign s_bready_o   = (state_q == S_B);
    assign frame_done_o = b_acc && last_q;
    assign busy_o       = (state_q != S_IDLE);

`ifdef PIXEL_AXI4_BRESP_ERR_CNT_EN
    logic [15:0] err_q, err_d;

    always_comb begin
        err_d = err_q;
        if (sof_acc)
            err_d = '0;
        else if (b_acc && s_bresp_i != '0 && err_q != 16'hFFFF)
            err_d = err_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_q <= '0;
        else
            err_q <= err_d;
    end

    assign err_cnt_o = err_q;
`endif

endmodule

// File: tb/tb_pixel_axi4_burst_tx.sv
// Directed bench for pixel_axi4_burst_tx with an AW/W/B scoreboard.
// Second instance covers a frame size that is not a multiple of the beat.
module tb_pixel_axi4_burst_tx;

    localparam int BL = 4;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  pxl = '0;
    logic        sof = 1'b0;
    logic        vld = 1'b0;
    logic        vld2 = 1'b0;
    logic        rdy, rdy2;
    logic [31:0] dcr = BASE;

    logic [4:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic        awvalid;
    logic        awready = 1'b1;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast, wvalid;
    logic        wready = 1'b1;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready, fdone, busy;

    logic [4:0]  awid2;
    logic [31:0] awaddr2;
    logic [7:0]  awlen2;
    logic [2:0]  awsize2;
    logic [1:0]  awburst2;
    logic        awvalid2;
    logic [31:0] wdata2;
    logic [3:0]  wstrb2;
    logic        wlast2, wvalid2, bready2, fdone2, busy2;
    logic        one = 1'b1;
    logic [4:0]  zid = '0;
    logic [1:0]  zresp = '0;

`ifdef PIXEL_AXI4_BRESP_ERR_CNT_EN
    logic [15:0] err_cnt, err_cnt2;
`endif

    always #5 clk = ~clk;

    pixel_axi4_burst_tx #(
        .BURST_LEN(BL), .FRAME_PXL(40)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .pxl_i(pxl), .pxl_vld_i(vld), .pxl_sof_i(sof), .pxl_rdy_o(rdy),
        .dcr_pxl_addr_i(dcr),
        .s_awid_o(awid), .s_awaddr_o(awaddr), .s_awlen_o(awlen),
        .s_awsize_o(awsize), .s_awburst_o(awburst),
        .s_awvalid_o(awvalid), .s_awready_i(awready),
        .s_wdata_o(wdata), .s_wstrb_o(wstrb), .s_wlast_o(wlast),
        .s_wvalid_o(wvalid), .s_wready_i(wready),
        .s_bid_i(zid), .s_bresp_i(bresp), .s_bvalid_i(bvalid),
        .s_bready_o(bready), .frame_done_o(fdone), .busy_o(busy)
`ifdef PIXEL_AXI4_BRESP_ERR_CNT_EN
        , .err_cnt_o(err_cnt)
`endif
    );

    pixel_axi4_burst_tx #(
        .BURST_LEN(BL), .FRAME_PXL(42)
    ) dut2 (
        .clk(clk), .rst_n(rst_n),
        .pxl_i(pxl), .pxl_vld_i(vld2), .pxl_sof_i(sof), .pxl_rdy_o(rdy2),
        .dcr_pxl_addr_i(dcr),
        .s_awid_o(awid2), .s_awaddr_o(awaddr2), .s_awlen_o(awlen2),
        .s_awsize_o(awsize2), .s_awburst_o(awburst2),
        .s_awvalid_o(awvalid2), .s_awready_i(one),
        .s_wdata_o(wdata2), .s_wstrb_o(wstrb2), .s_wlast_o(wlast2),
        .s_wvalid_o(wvalid2), .s_wready_i(one),
        .s_bid_i(zid), .s_bresp_i(zresp), .s_bvalid_i(one),
        .s_bready_o(bready2), .frame_done_o(fdone2), .busy_o(busy2)
`ifdef PIXEL_AXI4_BRESP_ERR_CNT_EN
        , .err_cnt_o(err_cnt2)
`endif
    );

    int npass = 0;
    int nchk = 0;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_t;
    typedef struct {
        logic [31:0] d;
        logic        l;
    } w_t;

    aw_t exp_aw[$];
    w_t  exp_w[$];
    bit  exp_b[$];

    // Reference model: pixel p of a frame carries value p[7:0].
    task automatic expect_frame(input int n);
        int nb;
        int cnt;
        int p;
        logic [31:0] d;
        nb = (n + 3) / 4;
        for (int b = 0; b < nb; b += BL) begin
            cnt = (nb - b < BL) ? nb - b : BL;
            exp_aw.push_back('{32'(BASE + b * 4), 8'(cnt - 1)});
            for (int j = 0; j < cnt; j++) begin
                d = '0;
                for (int k = 0; k < 4; k++) begin
                    p = (b + j) * 4 + k;
                    if (p < n)
                        d[k*8 +: 8] = 8'(p);
                end
                exp_w.push_back('{d, j == cnt - 1});
            end
            exp_b.push_back(b + BL >= nb);
        end
    endtask

    bit          stall = 1'b0;
    bit          abort = 1'b0;
    logic [7:0]  err_pat = '0;
    int          bbase = 0;
    int          bcnt = 0;
    int          aw_cnt = 0;
    bit          b_pend = 1'b0;
    bit          aw_open = 1'b0;
    bit          aw_hold = 1'b0;
    bit          w_hold = 1'b0;
    logic [39:0] hold_aw;
    logic [32:0] hold_w;

    always @(posedge clk) begin
        #1;
        awready = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        wready  = stall ? ($urandom_range(0, 3) == 0) : 1'b1;
        bvalid  = b_pend && (bvalid || !stall || $urandom_range(0, 3) == 0);
        bresp   = ((bcnt - bbase) < 8 && err_pat[(bcnt - bbase) % 8]) ?
                  2'b10 : 2'b00;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            b_pend  = 1'b0;
            aw_open = 1'b0;
            aw_hold = 1'b0;
            w_hold  = 1'b0;
        end else begin
            if (aw_hold)
                check("aw_stable", {awvalid, awaddr, awlen}, {1'b1, hold_aw});
            aw_hold = awvalid && !awready;
            hold_aw = {awaddr, awlen};
            if (w_hold)
                check("w_stable", {wvalid, wlast, wdata}, {1'b1, hold_w});
            w_hold = wvalid && !wready;
            hold_w = {wlast, wdata};
            if (wvalid)
                check("w_after_aw", aw_open, 1);
            if (awvalid && awready) begin
                check("aw_queue", exp_aw.size() > 0, 1);
                if (exp_aw.size() > 0) begin
                    check("awaddr", awaddr, exp_aw[0].addr);
                    check("awlen", awlen, exp_aw[0].len);
                    void'(exp_aw.pop_front());
                end
                aw_open = 1'b1;
                aw_cnt++;
            end
            if (wvalid && wready) begin
                check("w_queue", exp_w.size() > 0, 1);
                if (exp_w.size() > 0) begin
                    check("wdata", wdata, exp_w[0].d);
                    check("wlast", wlast, exp_w[0].l);
                    void'(exp_w.pop_front());
                end
                if (wlast) begin
                    aw_open = 1'b0;
                    b_pend  = 1'b1;
                end
            end
            if (bvalid && bready) begin
                check("b_queue", exp_b.size() > 0, 1);
                if (exp_b.size() > 0) begin
                    check("frame_done", fdone, exp_b[0]);
                    void'(exp_b.pop_front());
                end
                b_pend = 1'b0;
                bcnt++;
            end else if (fdone) begin
                check("frame_done_spur", fdone, 0);
            end
        end
    end

    logic [31:0] last_addr2 = '0;
    logic [31:0] last_data2 = '0;
    logic [7:0]  last_len2 = '0;
    int          nb2 = 0;
    int          fd2 = 0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (awvalid2) begin
                last_addr2 = awaddr2;
                last_len2  = awlen2;
                nb2++;
            end
            if (wvalid2 && wlast2)
                last_data2 = wdata2;
            if (fdone2)
                fd2++;
        end
    end

    task automatic send_pix(input logic [7:0] v, input bit s, input bit two);
        bit ok;
        pxl = v;
        sof = s;
        if (two) vld2 = 1'b1;
        else vld = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !abort; i++) begin
            @(negedge clk);
            if (two ? rdy2 : rdy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!abort)
            check("pix_accept", ok, 1);
        @(posedge clk);
        #1;
        vld  = 1'b0;
        vld2 = 1'b0;
        sof  = 1'b0;
    endtask

    task automatic send_frame(input int v0, input int n, input bit s,
                              input bit two);
        for (int i = 0; i < n; i++) begin
            if (abort) return;
            send_pix(8'(v0 + i), s && i == 0, two);
        end
    endtask

    task automatic wait_done();
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (exp_aw.size() + exp_w.size() + exp_b.size() == 0 && !busy)
                break;
        end
        check("drain_queue", exp_aw.size() + exp_w.size() + exp_b.size(), 0);
        check("drain_busy", busy, 0);
    endtask

    initial begin
        int a0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_pxl_rdy", rdy, 0);
        check("rst_awvalid", awvalid, 0);
        check("rst_awaddr", awaddr, 0);
        check("rst_awlen", awlen, 0);
        check("rst_wvalid", wvalid, 0);
        check("rst_wdata", wdata, 0);
        check("rst_wlast", wlast, 0);
        check("rst_bready", bready, 0);
        check("rst_fdone", fdone, 0);
        check("rst_busy", busy, 0);
        check("rst_const", {awid, awsize, awburst, wstrb},
              {5'd0, 3'd2, 2'b01, 4'hF});
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_rdy", rdy, 1);

        expect_frame(40);
        send_frame(0, 40, 1, 0);
        wait_done();

        send_frame(0, 42, 1, 1);
        for (int i = 0; i < 500 && fd2 == 0; i++)
            @(negedge clk);
        check("f42_done", fd2, 1);
        check("f42_bursts", nb2, 3);
        check("f42_addr", last_addr2, BASE + 32'h20);
        check("f42_len", last_len2, 2);
        check("f42_data", last_data2, 32'h0000_2928);

        send_frame(8'h50, 5, 0, 0);
        check("nosof_busy", busy, 0);
        expect_frame(40);
        send_frame(0, 40, 1, 0);
        wait_done();

        stall = 1'b1;
        expect_frame(40);
        send_frame(0, 40, 1, 0);
        wait_done();
        stall = 1'b0;

        send_frame(8'h60, 6, 1, 0);
        check("restart_busy", busy, 1);
        expect_frame(40);
        send_frame(0, 40, 1, 0);
        wait_done();

        a0 = aw_cnt;
        expect_frame(40);
        fork
            send_frame(0, 40, 1, 0);
            begin
                for (int i = 0; i < 3000; i++) begin
                    @(negedge clk);
                    if (aw_cnt >= a0 + 2 && wvalid) break;
                end
                check("reached_w2", aw_cnt >= a0 + 2 && wvalid, 1);
                #2;
                rst_n = 1'b0;
                abort = 1'b1;
            end
        join
        #1;
        check("mid_rst_out",
              {awvalid, wvalid, wlast, bready, fdone, busy, rdy}, 0);
        check("mid_rst_bus", {awaddr, awlen, wdata}, 0);
        @(posedge clk);
        #1;
        check("mid_rst_busy", busy, 0);
        exp_aw.delete();
        exp_w.delete();
        exp_b.delete();
        abort = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_rdy", rdy, 1);
        expect_frame(40);
        send_frame(0, 40, 1, 0);
        wait_done();

`ifdef PIXEL_AXI4_BRESP_ERR_CNT_EN
        bbase = bcnt;
        err_pat = 8'b0000_0101;
        expect_frame(40);
        send_frame(0, 40, 1, 0);
        wait_done();
        check("err_cnt", err_cnt, 2);
        err_pat = '0;
        bbase = bcnt + 8;
        expect_frame(40);
        send_pix(8'h00, 1, 0);
        check("err_clr", err_cnt, 0);
        for (int i = 1; i < 40; i++)
            send_pix(8'(i), 0, 0);
        wait_done();
`endif

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule

// File: doc/pixel_axi4_burst_tx.md
Name: pixel_axi4_burst_tx

Overview:
Parametrised successor of the single-beat pixel AXI4 writer in the DVP RX pipeline. It sits after the downscaler FIFO. It packs PXL_W-bit grayscale pixels into DATA_W-bit beats, buffers one burst, and issues AXI4 INCR write bursts of up to BURST_LEN beats to a frame buffer whose base address comes from the configuration register block. It is frame-aware: it restarts the address at start-of-frame, flushes a short final burst with zero padding, and pulses frame_done_o.

Parameters:
DATA_W, 32, AXI data width; must be a multiple of PXL_W.
ADDR_W, 32, AXI address width.
MST_ID_W, 5, AXI ID width.
TRANS_RESP_W, 2, BRESP width.
PXL_W, 8, pixel width.
BURST_LEN, 16, beats per full burst; allowed range 1..256.
FRAME_PXL, 76800, pixels per frame.
MST_ID, 0, constant value driven on s_awid_o.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
pxl_i  in  PXL_W  pixel data
pxl_vld_i  in  1  pixel valid
pxl_sof_i  in  1  first pixel of frame; qualified by pxl_vld_i
pxl_rdy_o  out  1  pixel ready
dcr_pxl_addr_i  in  ADDR_W  frame base address; byte address, DATA_W/8 aligned
s_awid_o  out  MST_ID_W  AW ID
s_awaddr_o  out  ADDR_W  burst start address
s_awlen_o  out  8  beats-1
s_awsize_o  out  3  log2(DATA_W/8), constant
s_awburst_o  out  2  2'b01 (INCR), constant
s_awvalid_o  out  1  AW valid
s_awready_i  in  1  AW ready
s_wdata_o  out  DATA_W  write data
s_wstrb_o  out  DATA_W/8  all ones
s_wlast_o  out  1  last beat of burst
s_wvalid_o  out  1  W valid
s_wready_i  in  1  W ready
s_bid_i  in  MST_ID_W  B ID, ignored
s_bresp_i  in  TRANS_RESP_W  B response
s_bvalid_i  in  1  B valid
s_bready_o  out  1  B ready
frame_done_o  out  1  one-cycle pulse when the last B of the frame is accepted
busy_o  out  1  high outside IDLE

Behaviour:
- Derived constant: PPB = DATA_W/PXL_W pixels per beat.
- Packing is little-endian: the first pixel of a beat occupies bits [PXL_W-1:0].
- The burst buffer is a register array of BURST_LEN words, plus a pixel counter, beat counter and frame pixel counter.
- Reset values: all outputs 0, except s_awid_o=MST_ID, s_awsize_o, s_awburst_o=2'b01 and s_wstrb_o all ones (constants). State=IDLE.
- States:
  - IDLE: pxl_rdy_o=1. Non-SOF pixels are accepted and dropped. An accepted SOF pixel latches dcr_pxl_addr_i as the burst address, clears the counters, packs the pixel as pixel 0, and moves to FILL.
  - FILL: pxl_rdy_o=1. Packs each accepted pixel. Exits to AW when the buffer holds BURST_LEN complete beats, or when the frame pixel count reaches FRAME_PXL. On the frame-end exit, a partial beat is zero-padded and the beat count becomes ceil(remaining pixels/PPB).
    - SOF in FILL discards the buffered data, re-latches the base address, and restarts the frame with this pixel as pixel 0. No AXI traffic is issued for the discarded data.
  - AW: pxl_rdy_o=0. s_awvalid_o=1 with s_awaddr_o=burst address and s_awlen_o=beats-1. AW, W, ADDR and len are held stable until s_awready_i. Then go to W.
  - W: s_wvalid_o=1. Beat k is driven from buffer[k]. The beat index advances on s_wvalid_o&&s_wready_i. s_wlast_o=1 on beat beats-1. After the last handshake go to B.
  - B: s_bready_o=1. On s_bvalid_i: burst address += beats*DATA_W/8, with wrap at 2^ADDR_W.
    - If it was the frame's final burst: pulse frame_done_o and go to IDLE.
    - Otherwise clear the buffer counters and go to FILL.
- W is never asserted before the AW handshake. At most one burst is outstanding.
- Throughput: the pixel path is stalled during AW/W/B. There is no bubble between FILL exit and AW (1 cycle).
- BRESP errors (SLVERR/DECERR) do not alter the flow.
- Asserting rst_n low mid-burst immediately forces IDLE and drops the in-flight burst. Outputs go to their reset values.

Optional Feature:
Macro PIXEL_AXI4_BRESP_ERR_CNT_EN.
- Defined: adds port err_cnt_o, out, 16 bits. It increments, saturating at 16'hFFFF, on each accepted B with s_bresp_i!=2'b00. It is cleared on reset and on every accepted SOF pixel.
- Undefined: the port and counter are absent and BRESP is ignored.

Test Plan:
All scenarios use DATA_W=32, PXL_W=8, BURST_LEN=4, FRAME_PXL=40, base 0x1000_0000, and ready signals held at 1.
1. Pixels 0x00..0x27 with SOF on 0x00 -> three bursts:
   - 0x1000_0000 len 3
   - 0x1000_0010 len 3
   - 0x1000_0020 len 1
   - First wdata=0x03020100; wlast on beats 4, 8, 10; one frame_done_o pulse after the third B.
2. FRAME_PXL=42, same stimulus extended to 0x29 -> final burst len 2; its last beat = 0x0000_2928.
3. 5 pixels without SOF, then a full frame -> the first 5 are dropped; AXI traffic is identical to scenario 1.
4. Random stalls on s_awready_i, s_wready_i and s_bvalid_i (0-7 cycles) -> AW/W signals stay stable while stalled, data is identical to scenario 1, and no W precedes AW.
5. SOF reasserted after 6 pixels of a frame -> no AXI traffic for the 6 pixels; the new frame starts at 0x1000_0000. Reset asserted during W of burst 2 -> all outputs 0 next edge and state IDLE.
6. With PIXEL_AXI4_BRESP_ERR_CNT_EN defined, BRESP=2'b10 on bursts 1 and 3 -> err_cnt_o=2; it clears to 0 on the next SOF.
